// File: rtl/video_pixel_stream_if.sv
// rtl/video_pixel_stream_if.sv - valid/ready RGB pixel source stream with frame marker
interface video_pixel_stream_if;
  logic [23:0] s_rgb;
  logic        s_sof;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_rgb, output s_sof, output s_valid, input s_ready);
  modport slave  (input s_rgb, input s_sof, input s_valid, output s_ready);
endinterface

// File: rtl/video_pixel_stream.sv
// rtl/video_pixel_stream.sv - raster timing, pixel FIFO and frame lock feeding the TMDS encoders
// PIXSTREAM_FILL_EN: when defined, missing pixels show FILL_RGB instead of black.
module video_pixel_stream #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [23:0] FILL_RGB   = 24'hFF00FF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  video_pixel_stream_if.slave   src,
  output logic [7:0]            red,
  output logic [7:0]            green,
  output logic [7:0]            blue,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic                  frame_start,
  output logic                  underflow,
  input  logic                  underflow_clr
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW = $clog2(H_TOTAL + 1);
  localparam int YW = $clog2(V_TOTAL + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_HS0  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] X_HS1  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_VS0  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] Y_VS1  = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

`ifdef PIXSTREAM_FILL_EN
  localparam logic [23:0] FILL_PIX = FILL_RGB;
`else
  localparam logic [23:0] FILL_PIX = FILL_RGB & 24'h000000;
`endif

  typedef enum logic {ST_SEEK, ST_LOCKED} state_t;

  state_t        state, state_next;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [24:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          ready_q, wr_en, pop, uf_set;
  logic          head_valid, head_sof, active, at_origin, hs_act, vs_act;
  logic [23:0]   head_rgb, pix_next;

  assign src.s_ready      = ready_q;
  assign wr_en            = src.s_valid && ready_q;
  assign head_valid       = (count != '0);
  assign {head_sof, head_rgb} = mem[rd_ptr];
  assign active           = (x < X_ACT) && (y < Y_ACT);
  assign at_origin        = (x == '0) && (y == '0);
  assign hs_act           = (x >= X_HS0) && (x < X_HS1);
  assign vs_act           = (y >= Y_VS0) && (y < Y_VS1);
  assign count_next       = count + (AW+1)'(wr_en) - (AW+1)'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (x == X_LAST) begin
      x <= '0;
      y <= (y == Y_LAST) ? '0 : y + 1'b1;
    end else begin
      x <= x + 1'b1;
    end
  end

  // Readiness is registered from the post-update fill level, so a full FIFO
  // refuses a write even when a pop happens in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count   <= count_next;
      ready_q <= (count_next != CNT_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {src.s_sof, src.s_rgb};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SEEK;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    uf_set     = 1'b0;
    pix_next   = active ? FILL_PIX : 24'h000000;
    case (state)
      ST_SEEK: begin
        // Drain until a frame marker sits at the head, then hold it for (0,0).
        if (head_valid) begin
          if (!head_sof) begin
            pop = 1'b1;
          end else if (at_origin) begin
            pop        = 1'b1;
            pix_next   = head_rgb;
            state_next = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (active) begin
          if (!head_valid) begin
            uf_set     = 1'b1;
            state_next = ST_SEEK;
          end else begin
            pop = 1'b1;
            if (head_sof && !at_origin) begin
              uf_set     = 1'b1;
              state_next = ST_SEEK;
            end else begin
              pix_next = head_rgb;
            end
          end
        end
      end
      default: state_next = ST_SEEK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red         <= 8'h00;
      green       <= 8'h00;
      blue        <= 8'h00;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      {red, green, blue} <= pix_next;
      hsync       <= hs_act ? HS_POL : ~HS_POL;
      vsync       <= vs_act ? VS_POL : ~VS_POL;
      de          <= active;
      frame_start <= at_origin;
      if (underflow_clr) underflow <= 1'b0;
      else if (uf_set)   underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_video_pixel_stream.sv
// tb/tb_video_pixel_stream.sv - self-checking bench for video_pixel_stream on a reduced raster
module tb_video_pixel_stream;
  localparam int HA = 8, HF = 2, HSN = 3, HB = 3;
  localparam int VA = 4, VF = 1, VSN = 2, VB = 1;
  localparam int DEPTH = 16;
  localparam int HT = HA + HF + HSN + HB;
  localparam int VT = VA + VF + VSN + VB;
  localparam int FR = HT * VT;
`ifdef PIXSTREAM_FILL_EN
  localparam logic [23:0] FILL = 24'hFF00FF;
`else
  localparam logic [23:0] FILL = 24'h000000;
`endif

  typedef struct {
    int         k;
    logic [3:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic underflow_clr = 1'b0;
  logic [7:0] red, green, blue;
  logic hsync, vsync, de, frame_start, underflow;

  video_pixel_stream_if bus();

  video_pixel_stream #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSN), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSN), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .FIFO_DEPTH(DEPTH), .FILL_RGB(24'hFF00FF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src(bus),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start),
    .underflow(underflow), .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cnt = 0, acc_cnt = 0, npix = 0;
  int src_val = 1, sof_val = 1;
  bit src_en = 1'b0;
  logic [23:0] last_pix;
  logic [3:0] hist [256];

  // reference model state
  int mx, my;
  bit mlock;
  logic [24:0] q [$];
  logic e_de, e_hs, e_vs, e_fs, e_uf, e_rdy;
  logic [23:0] e_pix;
  logic sn_rst, sn_valid, sn_sof, sn_ready, sn_clr;
  logic [23:0] sn_rgb;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit act, org, set_uf;
    logic [24:0] head;
    if (!sn_rst) begin
      mx = 0; my = 0; mlock = 0; q.delete();
      e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_uf = 0; e_rdy = 0; e_pix = '0;
      return;
    end
    act = (mx < HA) && (my < VA);
    org = (mx == 0) && (my == 0);
    set_uf = 0;
    e_pix = act ? FILL : 24'h0;
    if (!mlock) begin
      if (q.size() > 0) begin
        if (!q[0][24]) void'(q.pop_front());
        else if (org) begin head = q.pop_front(); e_pix = head[23:0]; mlock = 1; end
      end
    end else if (act) begin
      if (q.size() == 0) begin set_uf = 1; mlock = 0; end
      else begin
        head = q.pop_front();
        if (head[24] && !org) begin set_uf = 1; mlock = 0; end
        else e_pix = head[23:0];
      end
    end
    if (sn_valid && sn_ready) q.push_back({sn_sof, sn_rgb});
    e_rdy = (q.size() != DEPTH);
    e_de = act;
    e_fs = org;
    e_hs = (mx >= HA + HF) && (mx < HA + HF + HSN);
    e_vs = (my >= VA + VF) && (my < VA + VF + VSN);
    if (sn_clr) e_uf = 0;
    else if (set_uf) e_uf = 1;
    mx++;
    if (mx == HT) begin mx = 0; my = (my == VT - 1) ? 0 : my + 1; end
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_rgb = '0; bus.s_sof = 1'b0;
    forever begin
      @(negedge clk); #3;
      sn_rst = rst_n; sn_valid = bus.s_valid; sn_sof = bus.s_sof; sn_rgb = bus.s_rgb;
      sn_ready = bus.s_ready; sn_clr = underflow_clr;
      @(posedge clk);
      model_step();
      if (sn_rst && sn_valid && sn_ready) begin src_val++; acc_cnt++; end
      #2;
      check($sformatf("cycle%0d", cnt),
            {de, hsync, vsync, frame_start, underflow, bus.s_ready, red, green, blue},
            {e_de, e_hs, e_vs, e_fs, e_uf, e_rdy, e_pix});
      if (sn_rst) begin
        if (cnt < 256) hist[cnt] = {de, hsync, vsync, frame_start};
        cnt++;
      end else cnt = 0;
      if (de) begin npix++; last_pix = {red, green, blue}; end
      bus.s_valid = src_en;
      bus.s_rgb   = 24'(src_val);
      bus.s_sof   = (src_val == sof_val);
    end
  end

  task automatic wait_at(int pos);
    int n = 0;
    do begin @(negedge clk); n++; end while (((cnt % FR) != pos) && (n < 4 * FR));
    if (n >= 4 * FR) begin
      checks++; failures++;
      $display("FAIL wait_at%0d: got timeout expected position", pos);
    end
  endtask

  task automatic wait_fs(string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && (n < 3 * FR));
    check({name, "_fs_seen"}, frame_start, 1'b1);
  endtask

  task automatic pulse_clr();
    @(negedge clk); underflow_clr = 1'b1;
    @(negedge clk); underflow_clr = 1'b0;
  endtask

  initial begin
    vec_t tbl [14];
    int n_de, n_hs, n_vs, n;
    tbl[0]  = '{0,   4'b1001}; tbl[1]  = '{7,   4'b1000};
    tbl[2]  = '{8,   4'b0000}; tbl[3]  = '{9,   4'b0000};
    tbl[4]  = '{10,  4'b0100}; tbl[5]  = '{12,  4'b0100};
    tbl[6]  = '{13,  4'b0000}; tbl[7]  = '{16,  4'b1000};
    tbl[8]  = '{64,  4'b0000}; tbl[9]  = '{80,  4'b0010};
    tbl[10] = '{90,  4'b0110}; tbl[11] = '{111, 4'b0010};
    tbl[12] = '{112, 4'b0000}; tbl[13] = '{128, 4'b1001};

    // idle raster after reset
    repeat (3) @(negedge clk);
    check("reset_ready", bus.s_ready, 1'b0);
    rst_n = 1'b1;
    repeat (2 * FR + 4) @(negedge clk);
    for (int i = 0; i < 14; i++)
      check($sformatf("raster_k%0d", tbl[i].k), hist[tbl[i].k], tbl[i].exp);
    n_de = 0; n_hs = 0; n_vs = 0;
    for (int i = 0; i < FR; i++) begin
      n_de += int'(hist[i][3]); n_hs += int'(hist[i][2]); n_vs += int'(hist[i][1]);
    end
    check("de_per_frame", n_de, HA * VA);
    check("hs_per_frame", n_hs, HSN * VT);
    check("vs_per_frame", n_vs, VSN * HT);

    // continuous stream, sof on first word
    wait_at(100);
    src_val = 1; sof_val = 1; src_en = 1'b1;
    wait_fs("stream");
    check("stream_first_pix", {de, red, green, blue}, {1'b1, 24'h000001});
    npix = 1;
    repeat (2 * FR) @(negedge clk);
    check("stream_seq", last_pix, 24'(npix));
    check("stream_no_uf", underflow, 1'b0);

    // source stall while locked
    wait_at(19);
    src_en = 1'b0;
    repeat (200) @(negedge clk);
    check("stall_uf", underflow, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!de && n < FR);
    check("stall_fill", {de, red, green, blue}, {1'b1, FILL});
    wait_at(60);
    sof_val = src_val; src_en = 1'b1;
    pulse_clr();
    check("clr_uf", underflow, 1'b0);
    wait_fs("relock");
    check("relock_pix", {red, green, blue}, 24'(sof_val));
    repeat (FR) @(negedge clk);
    check("relock_no_uf", underflow, 1'b0);

    // stray sof mid-frame while locked
    wait_at(40);
    sof_val = src_val + 20;
    repeat (2 * FR) @(negedge clk);
    check("stray_sof_uf", underflow, 1'b1);
    wait_at(60);
    sof_val = src_val + 3;
    pulse_clr();
    wait_fs("stray_relock");
    check("stray_relock_pix", {red, green, blue}, 24'(sof_val));
    repeat (FR) @(negedge clk);
    check("stray_relock_no_uf", underflow, 1'b0);

    // reset mid-frame, then fill FIFO in blanking
    wait_at(50);
    rst_n = 1'b0;
    @(posedge clk); #3;
    check("midreset_out", {de, red, green, blue, hsync, vsync, underflow, bus.s_ready}, 28'h0);
    src_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    src_val = 1000; sof_val = 1000;
    wait_at(100);
    acc_cnt = 0; src_en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.s_ready && n < 40);
    check("fill_writes", acc_cnt, DEPTH);
    check("fill_in_blank", de, 1'b0);
    wait_fs("fill");
    check("fill_first_pix", {red, green, blue}, 24'd1000);
    npix = 1;
    repeat (2 * FR) @(negedge clk);
    check("fill_seq", last_pix, 24'(999 + npix));
    check("fill_no_uf", underflow, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
